// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_pkg : shared FSM encoding and geometry helpers for             |
// |                  mem_access_unit                                           |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int beats_f(input int v, input int mw);
        return v / mw;
    endfunction

    function automatic int lanes_f(input int mw, input int n);
        return mw / n;
    endfunction

    function automatic int ofs_f(input int mw);
        return $clog2(mw / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_read_return_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_return_pipe : RD_LAT-deep {valid, beat} tracker for in-flight reads   |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module read_return_pipe #(
    parameter int RD_LAT = 2,
    parameter int BW     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [BW-1:0] i_beat,
    output logic          o_cap,
    output logic [BW-1:0] o_cap_beat,
    output logic          o_empty
);

    logic [RD_LAT-1:0] r_valid;
    logic [BW-1:0]     r_beat [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_beat[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_beat[0]  <= i_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_beat[i]  <= r_beat[i-1];
            end
        end
    end

    assign o_cap      = r_valid[RD_LAT-1];
    assign o_cap_beat = r_beat[RD_LAT-1];

    // "Empty" means nothing remains once the beat in the last stage retires.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign o_empty = 1'b1;
        end else begin : g_latn
            assign o_empty = ~|r_valid[RD_LAT-2:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit : scalar/vector load-store sequencer for a narrow memory   |
// |                   port. Optional macro: MEM_ALIGN_CHECK_EN                 |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int N      = 32,
    parameter int V      = 256,
    parameter int MW     = 128,
    parameter int AW     = 14,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            mem_write,
    input  logic            vec_access,
    input  logic [N-1:0]    address,
    input  logic [N-1:0]    scalar_wdata,
    input  logic [V-1:0]    vector_wdata,
    output logic            busy,
    output logic            done,
    output logic            align_err,
    output logic [N-1:0]    scalar_rdata,
    output logic [V-1:0]    vector_rdata,
    output logic            mem_rden,
    output logic            mem_wren,
    output logic [AW-1:0]   mem_address,
    output logic [MW/8-1:0] mem_byteena,
    output logic [MW-1:0]   mem_wdata,
    input  logic [MW-1:0]   mem_rdata
);

    localparam int BEATS = beats_f(V, MW);
    localparam int LANES = lanes_f(MW, N);
    localparam int OFS   = ofs_f(MW);
    localparam int NB    = $clog2(N / 8);
    localparam int BEW   = MW / 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [BEW-1:0] c_SBE   = BEW'({(N/8){1'b1}});
    localparam logic [AW-1:0]  c_VMASK = AW'(BEATS - 1);

    state_t          r_state, w_state_n;
    logic [BW-1:0]   r_beat, w_beat_n, w_beat_inc;
    logic            r_write, r_vec;
    logic [AW-1:0]   r_base;
    logic [LW-1:0]   r_lane;
    logic [V-1:0]    r_vdata;
    logic            r_rden, r_wren, w_rden_n, w_wren_n;
    logic [AW-1:0]   r_addr, w_addr_n;
    logic [BEW-1:0]  r_be, w_be_n;
    logic [MW-1:0]   r_wdata, w_wdata_n;
    logic [N-1:0]    r_scalar_rdata;
    logic [V-1:0]    r_vector_rdata;
    logic            w_issue, w_last, w_accept;
    logic [AW-1:0]   w_req_base;
    logic [LW-1:0]   w_req_lane;
    logic            w_cap, w_pipe_empty;
    logic [BW-1:0]   w_cap_beat;

    // Vector bases are truncated to a whole-vector boundary.
    assign w_req_base = vec_access ? (AW'(address >> OFS) & ~c_VMASK) : AW'(address >> OFS);
    assign w_req_lane = (LANES > 1) ? LW'(address >> NB) : '0;
    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_beat_inc = r_beat + 1'b1;
    assign w_last     = r_vec ? (r_beat == BW'(BEATS - 1)) : 1'b1;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [N-1:0] c_SAMASK = N'(N/8 - 1);
    localparam logic [N-1:0] c_VAMASK = N'(V/8 - 1);
    logic w_misalign;
    logic r_align_err;
    assign w_misalign = vec_access ? (|(address & c_VAMASK)) : (|(address & c_SAMASK));
`endif

    always_comb begin
        w_state_n = r_state;
        w_beat_n  = r_beat;
        w_issue   = 1'b0;
        w_rden_n  = 1'b0;
        w_wren_n  = 1'b0;
        w_addr_n  = '0;
        w_be_n    = '0;
        w_wdata_n = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_beat_n = '0;
`ifdef MEM_ALIGN_CHECK_EN
                    if (w_misalign) begin
                        w_state_n = ST_DONE;
                    end else begin
                        w_state_n = mem_write ? ST_WRITE : ST_READ;
                        w_issue   = 1'b1;
                    end
`else
                    w_state_n = mem_write ? ST_WRITE : ST_READ;
                    w_issue   = 1'b1;
`endif
                end
            end
            ST_WRITE, ST_READ: begin
                if (w_last) begin
                    w_state_n = (r_state == ST_WRITE) ? ST_DONE : ST_DRAIN;
                end else begin
                    w_beat_n = w_beat_inc;
                    w_addr_n = r_base + AW'(w_beat_inc);
                    w_rden_n = ~r_write;
                    w_wren_n = r_write;
                    if (r_write) begin
                        w_wdata_n = r_vdata[w_beat_inc*MW +: MW];
                        w_be_n    = '1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_n = ST_DONE;
                end
            end
            ST_DONE:  w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase

        // Beat 0 is issued straight from the request inputs.
        if (w_issue) begin
            w_addr_n = w_req_base;
            w_rden_n = ~mem_write;
            w_wren_n = mem_write;
            if (mem_write) begin
                if (vec_access) begin
                    w_wdata_n = vector_wdata[MW-1:0];
                    w_be_n    = '1;
                end else begin
                    w_wdata_n = {LANES{scalar_wdata}};
                    w_be_n    = c_SBE << (w_req_lane * (N/8));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_rden  <= 1'b0;
            r_wren  <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_vec   <= 1'b0;
            r_base  <= '0;
            r_lane  <= '0;
            r_vdata <= '0;
        end else begin
            r_state <= w_state_n;
            r_beat  <= w_beat_n;
            r_rden  <= w_rden_n;
            r_wren  <= w_wren_n;
            r_addr  <= w_addr_n;
            r_be    <= w_be_n;
            r_wdata <= w_wdata_n;
            if (w_accept) begin
                r_write <= mem_write;
                r_vec   <= vec_access;
                r_base  <= w_req_base;
                r_lane  <= w_req_lane;
                r_vdata <= vector_wdata;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_align_err <= 1'b0;
        end else if (w_accept) begin
            r_align_err <= w_misalign;
        end
    end
    assign align_err = r_align_err && (r_state == ST_DONE);
`else
    assign align_err = 1'b0;
`endif

    read_return_pipe #(
        .RD_LAT (RD_LAT),
        .BW     (BW)
    ) u_rrp (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (r_rden),
        .i_beat     (r_beat),
        .o_cap      (w_cap),
        .o_cap_beat (w_cap_beat),
        .o_empty    (w_pipe_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scalar_rdata <= '0;
            r_vector_rdata <= '0;
        end else if (w_cap) begin
            if (r_vec) begin
                r_vector_rdata[w_cap_beat*MW +: MW] <= mem_rdata;
            end else begin
                r_scalar_rdata <= mem_rdata[r_lane*N +: N];
                r_vector_rdata <= V'(mem_rdata[r_lane*N +: N]);
            end
        end
    end

    assign busy         = w_accept || (r_state == ST_WRITE) || (r_state == ST_READ) ||
                          (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);
    assign scalar_rdata = r_scalar_rdata;
    assign vector_rdata = r_vector_rdata;
    assign mem_rden     = r_rden;
    assign mem_wren     = r_wren;
    assign mem_address  = r_addr;
    assign mem_byteena  = r_be;
    assign mem_wdata    = r_wdata;

endmodule
`default_nettype wire
